// File: rtl/m_ptw_mem_arbiter.sv
// Memory-side arbiter for the MMU page walker: shares one DRAM request port between walk reads,
// posted A/D write-backs and CPU accesses, and produces the walker's busy/read-data pair.
module m_ptw_mem_arbiter #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  CLK,
   input  logic                  RST_X,
   input  logic [2:0]            i_pw_state,
   input  logic                  i_pte_acs,
   input  logic [ADDR_WIDTH-1:0] i_pte_addr,
   input  logic                  i_pte_we,
   input  logic [DATA_WIDTH-1:0] i_pte_wdata,
   output logic                  o_busy,
   output logic [DATA_WIDTH-1:0] o_pte_rdata,
   input  logic                  i_cpu_req,
   input  logic                  i_cpu_we,
   input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
   input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
   output logic                  o_cpu_ack,
   output logic [DATA_WIDTH-1:0] o_cpu_rdata,
   output logic                  o_dram_req,
   output logic                  o_dram_we,
   output logic [ADDR_WIDTH-1:0] o_dram_addr,
   output logic [DATA_WIDTH-1:0] o_dram_wdata,
   input  logic                  i_dram_ready,
   input  logic                  i_dram_valid,
   input  logic [DATA_WIDTH-1:0] i_dram_rdata
);

   typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;
   typedef enum logic [1:0] {OwnPtwRd, OwnPtwWr, OwnCpu} owner_e;

   state_e                state_q;
   owner_e                owner_q;
   logic                  wbuf_v_q;
   logic [ADDR_WIDTH-1:0] wbuf_addr_q;
   logic [DATA_WIDTH-1:0] wbuf_data_q;
   logic                  r_ok_q;
   logic [ADDR_WIDTH-1:0] r_pte_addr_q;

   logic walk_rd;
   logic addr_latch;
   logic wb_capture;

   assign walk_rd    = (i_pw_state == 3'd1) || (i_pw_state == 3'd3);
   assign addr_latch = i_pte_acs && ((i_pw_state == 3'd0) || (i_pw_state == 3'd2));
   assign wb_capture = (i_pw_state == 3'd5) && i_pte_we && i_pte_acs;

   assign o_busy = (state_q != StIdle) || wbuf_v_q || (walk_rd && !r_ok_q);

   // DRAM request fields are registered at grant and zeroed once accepted.
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         state_q      <= StIdle;
         owner_q      <= OwnPtwRd;
         wbuf_v_q     <= 1'b0;
         wbuf_addr_q  <= '0;
         wbuf_data_q  <= '0;
         r_ok_q       <= 1'b0;
         r_pte_addr_q <= '0;
         o_pte_rdata  <= '0;
         o_cpu_ack    <= 1'b0;
         o_cpu_rdata  <= '0;
         o_dram_req   <= 1'b0;
         o_dram_we    <= 1'b0;
         o_dram_addr  <= '0;
         o_dram_wdata <= '0;
      end else begin
         o_cpu_ack <= 1'b0;
         if (addr_latch) r_pte_addr_q <= i_pte_addr;
         if (!walk_rd) r_ok_q <= 1'b0;

         unique case (state_q)
            StIdle: begin
               if (wbuf_v_q) begin
                  state_q      <= StReq;
                  owner_q      <= OwnPtwWr;
                  o_dram_req   <= 1'b1;
                  o_dram_we    <= 1'b1;
                  o_dram_addr  <= wbuf_addr_q;
                  o_dram_wdata <= wbuf_data_q;
               end else if (walk_rd && !r_ok_q) begin
                  state_q      <= StReq;
                  owner_q      <= OwnPtwRd;
                  o_dram_req   <= 1'b1;
                  o_dram_we    <= 1'b0;
                  o_dram_addr  <= r_pte_addr_q;
                  o_dram_wdata <= '0;
               // The ack cycle still sees the old request level, so it must not regrant.
               end else if (i_cpu_req && (i_pw_state == 3'd0) && !o_cpu_ack) begin
                  state_q      <= StReq;
                  owner_q      <= OwnCpu;
                  o_dram_req   <= 1'b1;
                  o_dram_we    <= i_cpu_we;
                  o_dram_addr  <= i_cpu_addr;
                  o_dram_wdata <= i_cpu_we ? i_cpu_wdata : '0;
               end
            end
            StReq: begin
               if (i_dram_ready) begin
                  state_q      <= StWait;
                  o_dram_req   <= 1'b0;
                  o_dram_we    <= 1'b0;
                  o_dram_addr  <= '0;
                  o_dram_wdata <= '0;
               end
            end
            StWait: begin
               if (i_dram_valid) begin
                  state_q <= StIdle;
                  unique case (owner_q)
                     OwnPtwRd: begin
                        o_pte_rdata <= i_dram_rdata;
                        if (walk_rd) r_ok_q <= 1'b1;
                     end
                     OwnPtwWr: wbuf_v_q <= 1'b0;
                     OwnCpu: begin
                        o_cpu_rdata <= i_dram_rdata;
                        o_cpu_ack   <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            default: state_q <= StIdle;
         endcase

         // A fresh write-back overrides completion of an older one.
         if (wb_capture) begin
            wbuf_v_q    <= 1'b1;
            wbuf_addr_q <= i_pte_addr;
            wbuf_data_q <= i_pte_wdata;
         end
      end
   end

endmodule

// File: tb/tb_m_ptw_mem_arbiter.sv
// Directed self-checking bench for m_ptw_mem_arbiter: walks, write-back, CPU contention,
// DRAM stalls and reset abort.
module tb_m_ptw_mem_arbiter;

   logic        CLK = 1'b0;
   logic        RST_X;
   logic [2:0]  i_pw_state;
   logic        i_pte_acs;
   logic [31:0] i_pte_addr;
   logic        i_pte_we;
   logic [31:0] i_pte_wdata;
   logic        o_busy;
   logic [31:0] o_pte_rdata;
   logic        i_cpu_req;
   logic        i_cpu_we;
   logic [31:0] i_cpu_addr;
   logic [31:0] i_cpu_wdata;
   logic        o_cpu_ack;
   logic [31:0] o_cpu_rdata;
   logic        o_dram_req;
   logic        o_dram_we;
   logic [31:0] o_dram_addr;
   logic [31:0] o_dram_wdata;
   logic        i_dram_ready;
   logic        i_dram_valid;
   logic [31:0] i_dram_rdata;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   m_ptw_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .CLK(CLK), .RST_X(RST_X),
      .i_pw_state(i_pw_state), .i_pte_acs(i_pte_acs), .i_pte_addr(i_pte_addr),
      .i_pte_we(i_pte_we), .i_pte_wdata(i_pte_wdata),
      .o_busy(o_busy), .o_pte_rdata(o_pte_rdata),
      .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr),
      .i_cpu_wdata(i_cpu_wdata), .o_cpu_ack(o_cpu_ack), .o_cpu_rdata(o_cpu_rdata),
      .o_dram_req(o_dram_req), .o_dram_we(o_dram_we), .o_dram_addr(o_dram_addr),
      .o_dram_wdata(o_dram_wdata), .i_dram_ready(i_dram_ready), .i_dram_valid(i_dram_valid),
      .i_dram_rdata(i_dram_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_idle_outputs(input string tag, input logic [31:0] pte, input logic [31:0] cpu);
      chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
      chk({tag, "_req"}, {31'd0, o_dram_req}, 32'd0);
      chk({tag, "_we"}, {31'd0, o_dram_we}, 32'd0);
      chk({tag, "_addr"}, o_dram_addr, 32'd0);
      chk({tag, "_wdata"}, o_dram_wdata, 32'd0);
      chk({tag, "_ack"}, {31'd0, o_cpu_ack}, 32'd0);
      chk({tag, "_pte_rdata"}, o_pte_rdata, pte);
      chk({tag, "_cpu_rdata"}, o_cpu_rdata, cpu);
   endtask

   // Expects a request to be visible now; stalls ready/valid and checks the held fields.
   task automatic serve(input string tag, input int rdy_wait, input int vld_wait,
                        input logic [31:0] data, input logic [31:0] exp_addr,
                        input logic exp_we, input logic [31:0] exp_wdata);
      for (int i = 0; i <= rdy_wait; i++) begin
         chk({tag, "_req"}, {31'd0, o_dram_req}, 32'd1);
         chk({tag, "_addr"}, o_dram_addr, exp_addr);
         chk({tag, "_we"}, {31'd0, o_dram_we}, {31'd0, exp_we});
         chk({tag, "_wdata"}, o_dram_wdata, exp_wdata);
         chk({tag, "_busy_req"}, {31'd0, o_busy}, 32'd1);
         if (i == rdy_wait) i_dram_ready = 1'b1;
         cyc();
         i_dram_ready = 1'b0;
      end
      for (int i = 0; i <= vld_wait; i++) begin
         chk({tag, "_req_wait"}, {31'd0, o_dram_req}, 32'd0);
         chk({tag, "_busy_wait"}, {31'd0, o_busy}, 32'd1);
         if (i == vld_wait) begin
            i_dram_valid = 1'b1;
            i_dram_rdata = data;
         end
         cyc();
         i_dram_valid = 1'b0;
         i_dram_rdata = 32'd0;
      end
   endtask

   initial begin
      RST_X = 1'b0;
      i_pw_state = 3'd0; i_pte_acs = 1'b0; i_pte_addr = 32'd0;
      i_pte_we = 1'b0; i_pte_wdata = 32'd0;
      i_cpu_req = 1'b0; i_cpu_we = 1'b0; i_cpu_addr = 32'd0; i_cpu_wdata = 32'd0;
      i_dram_ready = 1'b0; i_dram_valid = 1'b0; i_dram_rdata = 32'd0;
      cyc(); cyc();
      chk_idle_outputs("reset", 32'd0, 32'd0);
      RST_X = 1'b1;

      // L1 leaf walk
      i_pte_acs = 1'b1; i_pte_addr = 32'h8000_1004;
      cyc();
      chk("l1_pre_busy", {31'd0, o_busy}, 32'd0);
      i_pw_state = 3'd1; i_pte_acs = 1'b0; i_pte_addr = 32'd0;
      cyc();
      serve("l1", 0, 0, 32'h2000_00CF, 32'h8000_1004, 1'b0, 32'd0);
      chk("l1_rdata", o_pte_rdata, 32'h2000_00CF);
      chk("l1_busy_done", {31'd0, o_busy}, 32'd0);

      // Two-level walk
      i_pw_state = 3'd2; i_pte_acs = 1'b1; i_pte_addr = 32'h8000_2010;
      cyc();
      chk("l0_trans_busy", {31'd0, o_busy}, 32'd0);
      i_pw_state = 3'd3; i_pte_acs = 1'b0; i_pte_addr = 32'd0;
      cyc();
      serve("l0", 0, 0, 32'h2000_1001, 32'h8000_2010, 1'b0, 32'd0);
      chk("l0_rdata", o_pte_rdata, 32'h2000_1001);
      chk("l0_busy_done", {31'd0, o_busy}, 32'd0);
      i_pw_state = 3'd4;
      cyc();
      chk("l0_rdata_hold", o_pte_rdata, 32'h2000_1001);

      // Posted A/D write-back
      i_pw_state = 3'd5; i_pte_we = 1'b1; i_pte_acs = 1'b1;
      i_pte_addr = 32'h8000_2010; i_pte_wdata = 32'h0000_04C7;
      cyc();
      chk("wb_busy_next", {31'd0, o_busy}, 32'd1);
      chk("wb_no_req_yet", {31'd0, o_dram_req}, 32'd0);
      i_pw_state = 3'd0; i_pte_we = 1'b0; i_pte_acs = 1'b0;
      i_pte_addr = 32'd0; i_pte_wdata = 32'd0;
      cyc();
      serve("wb", 1, 1, 32'd0, 32'h8000_2010, 1'b1, 32'h0000_04C7);
      chk("wb_busy_done", {31'd0, o_busy}, 32'd0);
      chk("wb_rdata_hold", o_pte_rdata, 32'h2000_1001);

      // CPU vs walk contention
      i_pte_acs = 1'b1; i_pte_addr = 32'h8000_3000;
      cyc();
      i_pw_state = 3'd1; i_pte_acs = 1'b0; i_pte_addr = 32'd0;
      i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 32'h1000_0040;
      cyc();
      chk("cont_ack_early", {31'd0, o_cpu_ack}, 32'd0);
      serve("cont_walk", 0, 0, 32'h1111_1111, 32'h8000_3000, 1'b0, 32'd0);
      chk("cont_walk_rdata", o_pte_rdata, 32'h1111_1111);
      chk("cont_ack_walk", {31'd0, o_cpu_ack}, 32'd0);
      chk("cont_no_cpu_in_walk", {31'd0, o_dram_req}, 32'd0);
      i_pw_state = 3'd0;
      cyc();
      serve("cont_cpu", 0, 0, 32'hCAFE_F00D, 32'h1000_0040, 1'b0, 32'd0);
      chk("cont_ack", {31'd0, o_cpu_ack}, 32'd1);
      chk("cont_cpu_rdata", o_cpu_rdata, 32'hCAFE_F00D);
      i_cpu_req = 1'b0;
      cyc();
      chk("cont_ack_single", {31'd0, o_cpu_ack}, 32'd0);
      chk("cont_no_regrant", {31'd0, o_dram_req}, 32'd0);

      // CPU write with ready/valid stalls
      i_cpu_req = 1'b1; i_cpu_we = 1'b1; i_cpu_addr = 32'h1000_0080; i_cpu_wdata = 32'hDEAD_BEEF;
      cyc();
      serve("stall", 5, 3, 32'd0, 32'h1000_0080, 1'b1, 32'hDEAD_BEEF);
      chk("stall_ack", {31'd0, o_cpu_ack}, 32'd1);
      i_cpu_req = 1'b0; i_cpu_we = 1'b0; i_cpu_addr = 32'd0; i_cpu_wdata = 32'd0;
      cyc();
      chk("stall_ack_single", {31'd0, o_cpu_ack}, 32'd0);

      // Reset during WAIT with a posted write pending
      i_pw_state = 3'd5; i_pte_we = 1'b1; i_pte_acs = 1'b1;
      i_pte_addr = 32'h8000_4000; i_pte_wdata = 32'h0000_0055;
      cyc();
      i_pw_state = 3'd0; i_pte_we = 1'b0; i_pte_acs = 1'b0;
      i_pte_addr = 32'd0; i_pte_wdata = 32'd0;
      cyc();
      chk("rst_wb_req", {31'd0, o_dram_req}, 32'd1);
      i_dram_ready = 1'b1;
      cyc();
      i_dram_ready = 1'b0;
      chk("rst_in_wait_busy", {31'd0, o_busy}, 32'd1);
      RST_X = 1'b0;
      #1;
      chk_idle_outputs("rst_async", 32'd0, 32'd0);
      cyc();
      RST_X = 1'b1;
      i_dram_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("rst_after_req", {31'd0, o_dram_req}, 32'd0);
         chk("rst_after_busy", {31'd0, o_busy}, 32'd0);
         chk("rst_after_ack", {31'd0, o_cpu_ack}, 32'd0);
      end
      i_dram_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/m_ptw_mem_arbiter.md
# m_ptw_mem_arbiter

Memory-side companion of the MMU page walker. It sits between the MMU's PTE port (PTE address/strobe, walk state, A/D write-back) and the single DRAM request port, sharing that port with the CPU data path. It serialises walk reads, posted PTE write-backs and CPU accesses, and it generates the `busy`/read-data pair that the walker samples.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width on all ports
- DATA_WIDTH, 32, data width (one PTE per beat)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST_X  in  1  reset, asynchronous, active-low
- i_pw_state  in  3  walker state: 0 idle/start, 1 L1 read, 2 L1→L0, 3 L0 read, 4 check, 5 PTE update, 6 fault, 7 hit-done
- i_pte_acs  in  1  i_pte_addr is valid this cycle
- i_pte_addr  in  ADDR_WIDTH  PTE address from the walker
- i_pte_we  in  1  A/D write-back request; meaningful only when i_pw_state==5
- i_pte_wdata  in  DATA_WIDTH  updated PTE value
- o_busy  out  1  to the walker's DRAM-busy input
- o_pte_rdata  out  DATA_WIDTH  registered PTE read data to the walker
- i_cpu_req  in  1  CPU access request; level, held until ack
- i_cpu_we  in  1  CPU write
- i_cpu_addr  in  ADDR_WIDTH  CPU address
- i_cpu_wdata  in  DATA_WIDTH  CPU write data
- o_cpu_ack  out  1  one-cycle completion pulse
- o_cpu_rdata  out  DATA_WIDTH  CPU read data; valid with o_cpu_ack
- o_dram_req  out  1  request valid
- o_dram_we  out  1  write
- o_dram_addr  out  ADDR_WIDTH  request address
- o_dram_wdata  out  DATA_WIDTH  request write data
- i_dram_ready  in  1  request accepted this cycle
- i_dram_valid  in  1  completion (read data or write ack)
- i_dram_rdata  in  DATA_WIDTH  read data

## Operation
- Address latch: the block captures r_pte_addr ← i_pte_addr every cycle where i_pte_acs=1 and i_pw_state is 0 or 2. The walker drives 0 during states 1 and 3, so the latched value is the one used.
- FSM: IDLE, REQ, WAIT. An owner register records which source holds the port: PTW_RD, PTW_WR or CPU.
- Arbitration happens in IDLE only. The highest pending source wins:
  - Posted write: wbuf_v=1. Go to REQ, owner PTW_WR, using the wbuf address and data.
  - Walk read: i_pw_state∈{1,3} and r_ok=0. Go to REQ, owner PTW_RD, using r_pte_addr.
  - CPU: i_cpu_req=1 and i_pw_state==0. Go to REQ, owner CPU.
- REQ: drive o_dram_req=1 with the owner's fields. On i_dram_ready, go to WAIT.
- WAIT: on i_dram_valid, go to IDLE.
  - Owner PTW_RD: o_pte_rdata ← i_dram_rdata and r_ok ← 1.
  - Owner PTW_WR: wbuf_v ← 0.
  - Owner CPU: o_cpu_rdata ← i_dram_rdata and pulse o_cpu_ack.
- Posted write capture: when i_pw_state==5, i_pte_we=1 and i_pte_acs=1, the block loads wbuf ← {i_pte_addr, i_pte_wdata} and sets wbuf_v ← 1. The walker does not wait for completion.
- r_ok clears on any cycle where i_pw_state∉{1,3}.
- o_busy = (fsm≠IDLE) | wbuf_v | (i_pw_state∈{1,3} & ~r_ok). This is combinational from registers and i_pw_state.
- o_dram_we=1 only for owner PTW_WR or a CPU write. o_dram_addr, o_dram_wdata and o_dram_we are 0 when o_dram_req=0.

## Timing
- Reset values: fsm=IDLE, wbuf_v=0, r_ok=0, r_pte_addr=0. All outputs are 0, including o_busy, o_dram_req, o_cpu_ack, o_pte_rdata and o_cpu_rdata.
- A reset mid-transaction aborts it. A pending write-back is discarded, and no ack is issued afterwards.
- Walk read latency: walker enters state 1 at cycle k.
  - o_dram_req rises at k+1.
  - With ready at k+1 and valid at k+2, o_pte_rdata is updated and r_ok=1 at k+3, so o_busy=0 at k+3.
  - The walker samples the data at k+3.
- Write-back: wbuf_v=1 from the cycle after state 5. o_busy therefore blocks the next walk or hit-start in state 0 until the write completes.
- Simultaneous events in IDLE:
  - Walk read pending and i_cpu_req=1: the walk wins, and the CPU waits with no ack.
  - A CPU grant in the same cycle the walker leaves state 0: the CPU transaction completes first. o_busy then stays 1 until the walk read finishes.
- o_dram_req holds its fields stable until i_dram_ready. i_dram_valid in REQ or IDLE is ignored.
- o_pte_rdata holds its value between walk reads.
- o_cpu_ack is exactly one cycle per accepted request. The CPU must deassert i_cpu_req in the cycle after the ack, or it issues a new request.

## Test plan
- L1 leaf walk: pw 0→1 with i_pte_addr=0x8000_1004, DRAM returns 0x2000_00CF. Required: o_dram_addr=0x8000_1004 with we=0, o_busy=1 until r_ok, o_pte_rdata=0x2000_00CF, o_busy=0 while pw is still 1.
- Two-level walk: L1 read, pw=2 with i_pte_addr=0x8000_2010, pw=3. Required: second request at 0x8000_2010, and r_ok=0 at the first cycle of state 3.
- Posted A/D write: pw=5, we=1, addr=0x8000_2010, wdata=0x0000_04C7. Required: o_busy=1 from the next cycle, a write at 0x8000_2010 carrying 0x0000_04C7, o_busy low only after valid.
- CPU vs walk contention: i_cpu_req held while pw=1. Required: walk read issued first, CPU ack only after the walk data returns, a single ack pulse.
- Ready/valid stalls: hold i_dram_ready=0 for 5 cycles and i_dram_valid for 3 more. Required: stable request fields and o_busy=1 throughout.
- Reset during WAIT with wbuf_v=1: RST_X low for 1 cycle. Required: all outputs 0 immediately, no write issued after reset release.
